kgp_control_fsm: RTL and testbench

//  Multi-cycle control unit for the KGP-RISC datapath: decodes opcode/funccode, sequences FETCH-DECODE-EXEC-MEM-WB,

---
 rtl/kgp_control_fsm.sv | 146 ++++++++++++++
 tb/tb_kgp_control_fsm.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/kgp_control_fsm.sv
// kgp_control_fsm: multi-cycle KGP-RISC control unit; perf counters cycle_cnt/retire_cnt added when KGP_CTRL_PERF_EN is defined
module kgp_control_fsm #(
  parameter int OPC_W = 6,
`ifdef KGP_CTRL_PERF_EN
  parameter int CNT_W = 32,
`endif
  parameter int FUNC_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] funccode,
  input  logic              mem_ack,
  input  logic              carry_flag,
  input  logic              rs_zero,
  input  logic              rs_neg,
  output logic              ir_write,
  output logic [2:0]        alu_op,
  output logic [1:0]        alu_src,
  output logic              alu_frc,
  output logic              alu_dir,
  output logic              alu_arith,
  output logic              flags_we,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              br_link,
  output logic              reg_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
`ifdef KGP_CTRL_PERF_EN
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
`endif
  output logic              trap
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  state_t r_state, w_next;
  logic [OPC_W-1:0] r_opc;
  logic [FUNC_W-1:0] r_func;
  logic w_is_rr, w_is_ri, w_is_lg, w_is_sh, w_is_lw, w_is_sw, w_is_br, w_is_bl;
  logic w_legal, w_taken, w_sh_imm, w_sh_right, w_sh_arith;
  assign w_is_rr = r_opc == OPC_W'(0);
  assign w_is_ri = r_opc == OPC_W'(1);
  assign w_is_lg = r_opc == OPC_W'(2);
  assign w_is_sh = r_opc == OPC_W'(3);
  assign w_is_lw = r_opc == OPC_W'(4);
  assign w_is_sw = r_opc == OPC_W'(5);
  assign w_is_br = r_opc == OPC_W'(6);
  assign w_is_bl = w_is_br && r_func == FUNC_W'(5);
  assign w_legal = ((w_is_rr || w_is_ri || w_is_lg) && (r_func <= FUNC_W'(1)))
                || (w_is_sh && (r_func <= FUNC_W'(5)))
                || w_is_lw || w_is_sw
                || (w_is_br && (r_func <= FUNC_W'(7)));
  assign w_taken = (r_func == FUNC_W'(2)) ? rs_neg :
                   (r_func == FUNC_W'(3)) ? rs_zero :
                   (r_func == FUNC_W'(4)) ? !rs_zero :
                   (r_func == FUNC_W'(6)) ? carry_flag :
                   (r_func == FUNC_W'(7)) ? !carry_flag : 1'b1;
  assign w_sh_imm = r_func == FUNC_W'(0) || r_func == FUNC_W'(1) || r_func == FUNC_W'(4);
  assign w_sh_right = r_func == FUNC_W'(1) || r_func == FUNC_W'(3) || w_sh_arith;
  assign w_sh_arith = r_func == FUNC_W'(4) || r_func == FUNC_W'(5);
  // State register and instruction latch
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_opc <= '0;
      r_func <= '0;
    end else begin
      r_state <= w_next;
      if (ir_write) begin
        r_opc <= opcode;
        r_func <= funccode;
      end
    end
  // Next state and control outputs; everything forced low while reset is asserted
  always_comb begin
    w_next = r_state;
    instr_ready = 1'b0;
    ir_write = 1'b0;
    alu_op = 3'd0;
    alu_src = 2'd0;
    alu_frc = 1'b0;
    alu_dir = 1'b0;
    alu_arith = 1'b0;
    flags_we = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_to_reg = 1'b0;
    br_link = 1'b0;
    reg_write = 1'b0;
    pc_write = 1'b0;
    pc_src = 2'd0;
    trap = 1'b0;
    if (rst_n)
      case (r_state)
        S_FETCH: begin
          instr_ready = 1'b1;
          ir_write = instr_valid;
          w_next = instr_valid ? S_DECODE : S_FETCH;
        end
        S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          alu_op = w_is_sh ? 3'd4 : w_is_lg ? (r_func[0] ? 3'd3 : 3'd2) :
                   (w_is_rr || w_is_ri) ? {2'b00, r_func[0]} : 3'd0;
          alu_frc = w_is_ri || w_is_lw || w_is_sw;
          alu_src = alu_frc ? 2'd1 : (w_is_sh && w_sh_imm) ? 2'd2 : 2'd0;
          alu_dir = w_is_sh && w_sh_right;
          alu_arith = w_is_sh && w_sh_arith;
          flags_we = w_is_rr || w_is_ri;
          pc_write = w_is_br;
          pc_src = (w_is_br && w_taken) ? ((r_func == FUNC_W'(1)) ? 2'd2 : 2'd1) : 2'd0;
          br_link = w_is_bl;
          reg_write = w_is_bl;
          w_next = w_is_br ? S_FETCH : (w_is_lw || w_is_sw) ? S_MEM : S_WB;
        end
        S_MEM: begin
          mem_read = w_is_lw;
          mem_write = w_is_sw;
          pc_write = w_is_sw && mem_ack;
          w_next = mem_ack ? (w_is_lw ? S_WB : S_FETCH) : S_MEM;
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write = 1'b1;
          mem_to_reg = w_is_lw;
          w_next = S_FETCH;
        end
        S_TRAP: trap = 1'b1;
        default: w_next = S_FETCH;
      endcase
  end
`ifdef KGP_CTRL_PERF_EN
  // Cycle counter freezes in TRAP; retire counter follows pc_write pulses
  always_ff @(posedge clk)
    if (!rst_n) begin
      cycle_cnt <= '0;
      retire_cnt <= '0;
    end else begin
      if (r_state != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (pc_write) retire_cnt <= retire_cnt + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_kgp_control_fsm.sv
// tb_kgp_control_fsm: directed self-checking bench for kgp_control_fsm
module tb_kgp_control_fsm;
  typedef struct packed {
    logic ir_rdy, irw;
    logic [2:0] op;
    logic [1:0] src;
    logic frc, dir, ari, fwe, mrd, mwr, m2r, lnk, rw, pcw;
    logic [1:0] psrc;
    logic trp;
  } ctl_t;
  logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, mem_ack = 1'b0;
  logic carry_flag = 1'b0, rs_zero = 1'b0, rs_neg = 1'b0;
  logic [5:0] opcode = '0;
  logic [4:0] funccode = '0;
  logic instr_ready, ir_write, alu_frc, alu_dir, alu_arith, flags_we, mem_read, mem_write;
  logic mem_to_reg, br_link, reg_write, pc_write, trap;
  logic [2:0] alu_op;
  logic [1:0] alu_src, pc_src;
`ifdef KGP_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt, cy0, rt0;
`endif
  ctl_t obs, idle, e;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  kgp_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funccode(funccode), .mem_ack(mem_ack), .carry_flag(carry_flag),
    .rs_zero(rs_zero), .rs_neg(rs_neg), .ir_write(ir_write), .alu_op(alu_op),
    .alu_src(alu_src), .alu_frc(alu_frc), .alu_dir(alu_dir), .alu_arith(alu_arith),
    .flags_we(flags_we), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .br_link(br_link), .reg_write(reg_write), .pc_write(pc_write), .pc_src(pc_src),
`ifdef KGP_CTRL_PERF_EN
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
`endif
    .trap(trap)
  );
  assign obs = {instr_ready, ir_write, alu_op, alu_src, alu_frc, alu_dir, alu_arith, flags_we,
                mem_read, mem_write, mem_to_reg, br_link, reg_write, pc_write, pc_src, trap};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic look(input string tag, input ctl_t x);
    @(negedge clk);
    chk(tag, 32'(obs), 32'(x));
    @(posedge clk);
    #1;
  endtask
  function automatic ctl_t alu_e(input logic [2:0] op, input logic [1:0] src,
                                 input logic frc, dir, ari, fwe);
    ctl_t x = '0;
    x.op = op; x.src = src; x.frc = frc; x.dir = dir; x.ari = ari; x.fwe = fwe;
    return x;
  endfunction
  function automatic ctl_t br_e(input logic lnk, input logic [1:0] psrc);
    ctl_t x = '0;
    x.pcw = 1'b1; x.lnk = lnk; x.rw = lnk; x.psrc = psrc;
    return x;
  endfunction
  task automatic fetch_dec(input string tag, input logic [5:0] opc, input logic [4:0] fn);
    ctl_t x = '0;
    x.ir_rdy = 1'b1; x.irw = 1'b1;
    instr_valid = 1'b1; opcode = opc; funccode = fn;
    look({tag, "_f"}, x);
    instr_valid = 1'b0; opcode = 6'h3f; funccode = 5'h1f;
    look({tag, "_d"}, '0);
  endtask
  task automatic run_alu(input string tag, input logic [5:0] opc, input logic [4:0] fn, input ctl_t ex);
    ctl_t x = '0;
    fetch_dec(tag, opc, fn);
    look({tag, "_x"}, ex);
    x.rw = 1'b1; x.pcw = 1'b1;
    look({tag, "_wb"}, x);
  endtask
  task automatic run_br(input string tag, input logic [4:0] fn, input ctl_t ex);
    fetch_dec(tag, 6'd6, fn);
    look({tag, "_x"}, ex);
  endtask
  initial begin
    idle = '0; idle.ir_rdy = 1'b1;
    @(posedge clk); #1;
    look("rst0", '0);
    look("rst1", '0);
    rst_n = 1'b1;
    look("idle0", idle);
    run_alu("add", 6'd0, 5'd0, alu_e(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    look("add_c4", idle);
    run_alu("compi", 6'd1, 5'd1, alu_e(3'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    run_alu("and", 6'd2, 5'd0, alu_e(3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    run_alu("xor", 6'd2, 5'd1, alu_e(3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    run_alu("shll", 6'd3, 5'd0, alu_e(3'd4, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    run_alu("shrlv", 6'd3, 5'd3, alu_e(3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    run_alu("shra", 6'd3, 5'd4, alu_e(3'd4, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0));
    fetch_dec("lw", 6'd4, 5'd0);
    look("lw_x", alu_e(3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    e = '0; e.mrd = 1'b1;
    for (int i = 0; i < 3; i++) look($sformatf("lw_wait%0d", i), e);
    mem_ack = 1'b1;
    look("lw_ack", e);
    mem_ack = 1'b0;
    e = '0; e.rw = 1'b1; e.pcw = 1'b1; e.m2r = 1'b1;
    look("lw_wb", e);
    look("lw_done", idle);
    mem_ack = 1'b1;
    fetch_dec("sw", 6'd5, 5'd0);
    look("sw_x", alu_e(3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    e = '0; e.mwr = 1'b1; e.pcw = 1'b1;
    look("sw_mem", e);
    mem_ack = 1'b0;
    look("sw_done", idle);
    rs_zero = 1'b1;
    run_br("bz_t", 5'd3, br_e(1'b0, 2'd1));
    rs_zero = 1'b0;
    run_br("bz_n", 5'd3, br_e(1'b0, 2'd0));
    run_br("bnz_t", 5'd4, br_e(1'b0, 2'd1));
    run_br("bl", 5'd5, br_e(1'b1, 2'd1));
    run_br("br", 5'd1, br_e(1'b0, 2'd2));
    run_br("b", 5'd0, br_e(1'b0, 2'd1));
    rs_neg = 1'b1;
    run_br("bltz_t", 5'd2, br_e(1'b0, 2'd1));
    rs_neg = 1'b0;
    run_br("bltz_n", 5'd2, br_e(1'b0, 2'd0));
    carry_flag = 1'b1;
    run_br("bcy_t", 5'd6, br_e(1'b0, 2'd1));
    run_br("bncy_n", 5'd7, br_e(1'b0, 2'd0));
    carry_flag = 1'b0;
    run_br("bncy_t", 5'd7, br_e(1'b0, 2'd1));
    look("br_done", idle);
    fetch_dec("rstmem", 6'd4, 5'd0);
    look("rstmem_x", alu_e(3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    e = '0; e.mrd = 1'b1;
    look("rstmem_m", e);
    rst_n = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) look($sformatf("rstmem_r%0d", i), '0);
    rst_n = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) look($sformatf("rstmem_idle%0d", i), idle);
    fetch_dec("ill7", 6'd7, 5'd0);
    instr_valid = 1'b1; opcode = 6'd0; funccode = 5'd0;
    e = '0; e.trp = 1'b1;
    for (int i = 0; i < 20; i++) look($sformatf("trap%0d", i), e);
    rst_n = 1'b0; instr_valid = 1'b0;
    look("trap_rst", '0);
    rst_n = 1'b1;
    look("trap_clr", idle);
    fetch_dec("illf", 6'd0, 5'd2);
    look("illf_t", e);
    rst_n = 1'b0;
    look("illf_rst", '0);
    rst_n = 1'b1;
    fetch_dec("ills", 6'd3, 5'd6);
    look("ills_t", e);
    rst_n = 1'b0;
    look("ills_rst", '0);
    rst_n = 1'b1;
    look("ills_clr", idle);
`ifdef KGP_CTRL_PERF_EN
    instr_valid = 1'b1; opcode = 6'd0; funccode = 5'd0;
    @(negedge clk);
    cy0 = cycle_cnt; rt0 = retire_cnt;
    repeat (40) @(negedge clk);
    instr_valid = 1'b0;
    chk("perf_cyc", cycle_cnt - cy0, 32'd40);
    chk("perf_ret", retire_cnt - rt0, 32'd10);
    @(posedge clk); #1;
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
